seq_multiplier: RTL and testbench
=================================

Name: seq_multiplier

Overview:
- Iterative shift-add unsigned multiplier; the inverse-operation companion to the ALU divide unit.
- Shares that unit's operand/result convention: op1, op2, result, with width taken from the shared data-width definition.
- Adds a start/busy/done handshake so the CPU control can stall on a multi-cycle multiply.
- Produces the full double-width product (low and high halves) plus an overflow flag.

Parameters:
- WIDTH, 32, operand and result width; must equal the shared data width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  single system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  start request; sampled only when not busy.
- op1  input  WIDTH  multiplicand, unsigned.
- op2  input  WIDTH  multiplier, unsigned.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when result/result_hi become valid.
- result  output  WIDTH  low half of op1*op2.
- result_hi  output  WIDTH  high half of op1*op2.
- overflow  output  1  high when result_hi is nonzero.

Behaviour:
- Reset, asynchronous and active-high:
  - state goes to IDLE.
  - busy, done and overflow go to 0.
  - result and result_hi go to 0.
  - Internal accumulator, operand registers and counter are cleared.
- State machine has three states:
  - IDLE: enable=1 at a rising edge latches op1 into the multiplicand register and op2 into the low half of the product register. It clears the high half and the carry, loads counter=WIDTH, and moves to RUN. busy=1 from that edge.
  - RUN: each cycle, if product LSB=1 then the upper half becomes upper half + multiplicand, computed at WIDTH+1 bits to keep the carry. The {carry, upper, lower} register then shifts right by 1, and the counter decrements. When the counter reaches 1 in RUN, that edge performs the last step and moves to DONE.
  - DONE: for one cycle, result, result_hi and overflow are registered from the final product, done=1 and busy=0. The next state is IDLE, or RUN if enable=1 in this cycle.
- Latency:
  - enable sampled at edge N gives done high in the cycle following edge N+WIDTH+1.
  - Latency is fixed and independent of operand values; there are no zero or one shortcuts.
- Output hold: result, result_hi and overflow hold their last values until the next DONE update. Only done is a pulse.
- enable while busy=1 is ignored; the operands are not re-latched and the in-flight operation is unaffected.
- op1 and op2 may change freely after the start edge, because the operands are latched.
- Back-to-back operation: enable asserted during the DONE cycle starts a new operation at that edge, with no IDLE bubble.
- Reset asserted mid-operation aborts immediately. All outputs go to their reset values and no done pulse is produced.
- Arithmetic: the product is exact over 2*WIDTH bits and never wraps. overflow is the OR-reduction of result_hi.

Decomposition:
- Shared constants file: data width (WIDTH source) and state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2. These are shared with any future iterative ALU units.
- One natural sub-module, mul_step: purely combinational. Given the current {carry, upper, lower} and the multiplicand, it returns the next shifted product register. The top level holds the FSM, counter and registers.

Test Plan (WIDTH=32):
- op1=3, op2=5, enable one cycle -> done one pulse 34 cycles after the start edge; result=0x0000000F, result_hi=0, overflow=0; busy high throughout the operation.
- op1=0xFFFFFFFF, op2=0xFFFFFFFF -> result=0x00000001, result_hi=0xFFFFFFFE, overflow=1.
- op1=0, op2=0x12345678 -> result=0, result_hi=0, overflow=0, with the same fixed latency.
- Start 0x10000*0x10000, pulse enable with 7*9 at cycle 10 while busy -> only result_hi=0x00000001, result=0 produced; no second done.
- Start 6*7, assert reset at cycle 15 for 2 cycles -> all outputs 0 immediately, no done. Then start 6*7 again -> result=42 after full latency.
- Back-to-back: enable held high with 2*3 then 4*5 presented in the DONE cycle -> done pulses 33 cycles apart; results 6 then 20.

Source files
------------

// File: rtl/seq_multiplier_pkg.sv
// Shared constants for the iterative ALU units: data width and FSM state encodings.
package seq_multiplier_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : seq_multiplier_pkg

// File: rtl/seq_multiplier_if.sv
// Start/busy/done handshake plus operand and result bus of the sequential multiplier.
interface seq_multiplier_if
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = DATA_W
);

  logic             enable;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             overflow;

  modport master (
    output enable, op1, op2,
    input  busy, done, result, result_hi, overflow
  );

  modport slave (
    input  enable, op1, op2,
    output busy, done, result, result_hi, overflow
  );

endinterface : seq_multiplier_if

// File: rtl/seq_multiplier_mul_step.sv
// One shift-add iteration: conditionally add the multiplicand into the upper
// half, then shift the whole {carry, upper, lower} register right by one.
module mul_step
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic [2*WIDTH:0]  prod_i,
  input  logic [WIDTH-1:0]  mcand_i,
  output logic [2*WIDTH:0]  prod_o
);

  logic [WIDTH:0]   upper_sum;
  logic [2*WIDTH:0] pre_shift;

  // Upper half is widened by one bit so the add carry survives into the shift.
  always_comb begin
    upper_sum = prod_i[2*WIDTH:WIDTH];
    if (prod_i[0]) begin
      upper_sum = {1'b0, prod_i[2*WIDTH-1:WIDTH]} + {1'b0, mcand_i};
    end
    pre_shift = {upper_sum, prod_i[WIDTH-1:0]};
    prod_o    = pre_shift >> 1;
  end

endmodule : mul_step

// File: rtl/seq_multiplier.sv
// Iterative shift-add unsigned multiplier with start/busy/done handshake.
// Produces the full double-width product and an overflow flag (high half != 0).
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for enable; outputs hold the last result
//   RUN   | one shift-add step per cycle, counter counts WIDTH down to 1
//   DONE  | product final; next edge registers outputs and pulses done,
//         | and may restart immediately if enable is high
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int CNT_W = 6
) (
  input  logic              clock,
  input  logic              reset,
  seq_multiplier_if.slave   bus
);

  localparam int PW = 2 * WIDTH + 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             overflow_q, overflow_d;

  logic [PW-1:0]    prod_step;

  mul_step #(
    .WIDTH (WIDTH)
  ) u_mul_step (
    .prod_i  (prod_q),
    .mcand_i (mcand_q),
    .prod_o  (prod_step)
  );

  // Next-state, datapath and registered-output logic for the multiply FSM.
  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    prod_d      = prod_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    overflow_d  = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (bus.enable) begin
          mcand_d = bus.op1;
          prod_d  = {1'b0, {WIDTH{1'b0}}, bus.op2};
          cnt_d   = CNT_W'(WIDTH);
          state_d = RUN;
        end
      end

      RUN: begin
        prod_d = prod_step;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        done_d      = 1'b1;
        result_d    = prod_q[WIDTH-1:0];
        result_hi_d = prod_q[2*WIDTH-1:WIDTH];
        overflow_d  = |prod_q[2*WIDTH-1:WIDTH];
        state_d     = IDLE;
        // Back-to-back start: the product register is reloaded on the same
        // edge that copies the finished product into the output registers.
        if (bus.enable) begin
          mcand_d = bus.op1;
          prod_d  = {1'b0, {WIDTH{1'b0}}, bus.op2};
          cnt_d   = CNT_W'(WIDTH);
          state_d = RUN;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and all registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      prod_q      <= prod_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.result_hi = result_hi_q;
  assign bus.overflow  = overflow_q;

endmodule : seq_multiplier

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: vector table plus hand-written
// sequences for abort, ignored enable and back-to-back operation.
module tb_seq_multiplier;
  import seq_multiplier_pkg::*;

  localparam int W   = DATA_W;
  localparam int LAT = W + 1;  // negedges after start edge until done is seen

  logic clock = 1'b0;
  logic reset = 1'b1;

  seq_multiplier_if #(.WIDTH(W)) bus ();

  seq_multiplier #(
    .WIDTH (W),
    .CNT_W (6)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         ovf;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         ovf;
    string        name;
  } vec_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   done_count = 0;
  int   last_done_cyc = 0;
  int   prev_done_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  always @(posedge clock) cyc++;

  // Scoreboard: every done pulse pops one expected result.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (!reset && bus.done === 1'b1) begin
      done_count++;
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("result", 64'(bus.result), 64'(e.lo));
        check("result_hi", 64'(bus.result_hi), 64'(e.hi));
        check("overflow", 64'(bus.overflow), 64'(e.ovf));
      end
    end
  end

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    bus.op1    = a;
    bus.op2    = b;
    bus.enable = 1'b1;
    @(posedge clock);
    #1;
    bus.enable = 1'b0;
    bus.op1    = $urandom;
    bus.op2    = $urandom;
  endtask

  task automatic wait_done(input string name, input int exp_lat);
    int  k;
    bit  seen;
    bit  busy_ok;
    seen    = 1'b0;
    busy_ok = 1'b1;
    for (k = 0; k < 60; k++) begin
      @(negedge clock);
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
    end
    check({name, "_latency"}, seen ? 64'(k) : 64'd999, 64'(exp_lat));
    check({name, "_busy"}, 64'(busy_ok), 64'd1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] lo, input logic [W-1:0] hi,
                        input logic ovf, input string name);
    exp_t e;
    e.lo = lo; e.hi = hi; e.ovf = ovf;
    exp_q.push_back(e);
    start_op(a, b);
    wait_done(name, LAT);
    @(negedge clock);
    check({name, "_done_pulse"}, 64'(bus.done), 64'd0);
    check({name, "_busy_after"}, 64'(bus.busy), 64'd0);
    check({name, "_hold_lo"}, 64'(bus.result), 64'(lo));
    check({name, "_hold_hi"}, 64'(bus.result_hi), 64'(hi));
  endtask

  vec_t vecs[7];

  initial begin
    int           dc;
    logic [W-1:0] ra, rb;
    logic [63:0]  rp;
    exp_t         e;

    vecs[0] = '{32'd3, 32'd5, 32'h0000000F, 32'h0, 1'b0, "v3x5"};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b1, "vmax"};
    vecs[2] = '{32'h0, 32'h12345678, 32'h0, 32'h0, 1'b0, "vzero"};
    vecs[3] = '{32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0, "vone"};
    vecs[4] = '{32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001, 32'h0, 1'b0, "v16max"};
    vecs[5] = '{32'h00010000, 32'h00010000, 32'h0, 32'h00000001, 1'b1, "v2p32"};
    vecs[6] = '{32'h80000000, 32'h80000000, 32'h0, 32'h40000000, 1'b1, "vmsb"};

    bus.enable = 1'b0;
    bus.op1    = '0;
    bus.op2    = '0;

    repeat (2) @(negedge clock);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_result_hi", 64'(bus.result_hi), 64'd0);
    check("rst_overflow", 64'(bus.overflow), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi, vecs[i].ovf, vecs[i].name);
    end

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      rp = {32'd0, ra} * {32'd0, rb};
      run_op(ra, rb, rp[W-1:0], rp[2*W-1:W], |rp[2*W-1:W], "vrand");
    end

    // Leave a nonzero result so the abort can be seen clearing it.
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b1, "pre_abort");

    // Abort mid-operation: async reset clears outputs at once, no done follows.
    start_op(32'd6, 32'd7);
    repeat (14) @(negedge clock);
    reset = 1'b1;
    #1;
    check("abort_result", 64'(bus.result), 64'd0);
    check("abort_result_hi", 64'(bus.result_hi), 64'd0);
    check("abort_overflow", 64'(bus.overflow), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    dc = done_count;
    repeat (45) @(negedge clock);
    check("abort_no_done", 64'(done_count), 64'(dc));
    run_op(32'd6, 32'd7, 32'd42, 32'd0, 1'b0, "post_abort");

    // Enable while busy is ignored: one result, one done.
    e.lo = 32'h0; e.hi = 32'h1; e.ovf = 1'b1;
    exp_q.push_back(e);
    dc = done_count;
    start_op(32'h00010000, 32'h00010000);
    repeat (9) @(negedge clock);
    bus.op1    = 32'd7;
    bus.op2    = 32'd9;
    bus.enable = 1'b1;
    @(negedge clock);
    bus.enable = 1'b0;
    wait_done("ignore", LAT - 10);
    repeat (45) @(negedge clock);
    check("ignore_one_done", 64'(done_count), 64'(dc + 1));

    // Back-to-back: second operands presented during the DONE cycle.
    e.lo = 32'd6;  e.hi = 32'd0; e.ovf = 1'b0;
    exp_q.push_back(e);
    e.lo = 32'd20;
    exp_q.push_back(e);
    dc = done_count;
    @(negedge clock);
    bus.op1    = 32'd2;
    bus.op2    = 32'd3;
    bus.enable = 1'b1;
    @(posedge clock);
    repeat (33) @(negedge clock);
    bus.op1 = 32'd4;
    bus.op2 = 32'd5;
    @(posedge clock);
    #1;
    bus.enable = 1'b0;
    bus.op1    = $urandom;
    bus.op2    = $urandom;
    for (int k = 0; k < 80; k++) begin
      @(negedge clock);
      if (done_count >= dc + 2) break;
    end
    check("b2b_done_count", 64'(done_count), 64'(dc + 2));
    check("b2b_spacing", 64'(last_done_cyc - prev_done_cyc), 64'd33);
    repeat (3) @(negedge clock);
    check("b2b_busy_after", 64'(bus.busy), 64'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_seq_multiplier
